// File: rtl/parity_steer_router.sv
// Lane selector with parity-steered destination, delivered through one valid/ready stage.
// Optional per-channel drain counters are built when ROUTER_STATS_EN is defined.
module parity_steer_router #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PAR_W = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [PAR_W-1:0]        in_par_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_CH*WIDTH-1:0]   out_data,
    output logic [N_CH-1:0]         out_valid,
    input  logic [N_CH-1:0]         out_ready,
    output logic [SEL_W-1:0]        route_dest
`ifdef ROUTER_STATS_EN
    ,
    input  logic                    cnt_clr,
    output logic [N_CH*CNT_W-1:0]   cnt_flat
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [N_CH*WIDTH-1:0]   out_data_q, out_data_d;
    logic [N_CH-1:0]         out_valid_q, out_valid_d;
    logic [SEL_W-1:0]        route_dest_q, route_dest_d;

    logic                    full;
    logic                    drain;
    logic                    accept;
    logic                    par;
    logic [SEL_W-1:0]        dest;
    logic [WIDTH-1:0]        payload;

    // Next-state, steering and stage update
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        route_dest_d = route_dest_q;
        payload      = '0;

        full     = (state_q == ST_FULL);
        drain    = full & out_ready[route_dest_q];
        in_ready = ~full | out_ready[route_dest_q];
        accept   = in_valid & in_ready;
        par      = ^in_par_data;
        dest     = par ? in_sel : ~in_sel;

        for (int k = 0; k < int'(N_CH); k++) begin
            if (in_sel == SEL_W'(k)) payload = in_data[k*WIDTH +: WIDTH];
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (drain && !accept) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            route_dest_d = dest;
            for (int k = 0; k < int'(N_CH); k++) begin
                out_valid_d[k]              = (dest == SEL_W'(k));
                out_data_d[k*WIDTH +: WIDTH] = (dest == SEL_W'(k)) ? payload : '0;
            end
        end else if (drain) begin
            out_valid_d = '0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_valid_q  <= '0;
            route_dest_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            route_dest_q <= route_dest_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign route_dest = route_dest_q;

`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Saturating drain counters; clear has priority over increment
    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (drain && (route_dest_q == SEL_W'(k)) && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_CH); k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(N_CH); k++) cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_parity_steer_router.sv
// Self-checking bench for parity_steer_router: behavioural model compared every cycle plus literal checks.
module tb_parity_steer_router;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  in_par_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  route_dest;
`ifdef ROUTER_STATS_EN
    logic        cnt_clr;
    logic [31:0] cnt_flat;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    parity_steer_router #(
        .WIDTH(8), .N_CH(4), .PAR_W(4), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_par_data(in_par_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .route_dest (route_dest)
`ifdef ROUTER_STATS_EN
        ,
        .cnt_clr    (cnt_clr),
        .cnt_flat   (cnt_flat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a single slot holding (dest, payload); counters as plain ints
    bit         m_full;
    int         m_dest;
    logic [7:0] m_pay;
    int         m_cnt [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 0;
            m_dest = 0;
            m_pay  = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            bit drained;
            bit rdy;
            drained = m_full && out_ready[m_dest];
            rdy     = !m_full || out_ready[m_dest];
`ifdef ROUTER_STATS_EN
            if (cnt_clr) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end else if (drained && m_cnt[m_dest] < 255) begin
                m_cnt[m_dest] = m_cnt[m_dest] + 1;
            end
`endif
            if (in_valid && rdy) begin
                m_full = 1;
                m_dest = (^in_par_data) ? int'(in_sel) : 3 - int'(in_sel);
                m_pay  = 8'(in_data >> (8 * int'(in_sel)));
            end else if (drained) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_d;
            logic [3:0]  exp_v;
            exp_d = '0;
            exp_v = '0;
            if (m_full) begin
                exp_v[m_dest] = 1'b1;
                exp_d[m_dest*8 +: 8] = m_pay;
            end
            chk("cyc_out_valid", 64'(out_valid), 64'(exp_v));
            chk("cyc_out_data", 64'(out_data), 64'(exp_d));
            chk("cyc_route_dest", 64'(route_dest), 64'(m_dest));
            chk("cyc_in_ready", 64'(in_ready), 64'(!m_full || out_ready[m_dest]));
`ifdef ROUTER_STATS_EN
            for (int k = 0; k < 4; k++) chk("cyc_cnt", 64'(cnt_flat[k*8 +: 8]), 64'(m_cnt[k]));
`endif
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic [3:0] p, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid    = v;
        in_sel      = s;
        in_par_data = p;
        out_ready   = r;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data     = '0;
        in_sel      = '0;
        in_par_data = '0;
        in_valid    = 1'b0;
        out_ready   = '0;
`ifdef ROUTER_STATS_EN
        cnt_clr     = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_route_dest", 64'(route_dest), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // Odd parity: destination equals source select
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        step(1'b1, 2'd2, 4'b0001, 4'b0000);
        step(1'b0, 2'd2, 4'b0001, 4'b0000);
        settle();
        chk("odd_out_valid", 64'(out_valid), 64'h4);
        chk("odd_out_data", 64'(out_data), 64'h0033_0000);
        chk("odd_route_dest", 64'(route_dest), 64'h2);
        step(1'b0, 2'd2, 4'b0001, 4'b0100);
        step(1'b0, 2'd2, 4'b0001, 4'b0000);
        settle();
        chk("drain_out_valid", 64'(out_valid), 64'h0);
        chk("drain_out_data", 64'(out_data), 64'h0);

        // Even parity: destination is the inverted select
        step(1'b1, 2'd2, 4'b0011, 4'b0000);
        step(1'b0, 2'd2, 4'b0011, 4'b0000);
        settle();
        chk("even_out_valid", 64'(out_valid), 64'h2);
        chk("even_out_data", 64'(out_data), 64'h0000_3300);
        chk("even_route_dest", 64'(route_dest), 64'h1);

        // Stall with only non-destination channels ready
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 4'b0000, 4'b1101);
            settle();
            chk("stall_in_ready", 64'(in_ready), 64'h0);
            chk("stall_out_valid", 64'(out_valid), 64'h2);
            chk("stall_out_data", 64'(out_data), 64'h0000_3300);
        end
        // Drain and accept together: sel 0, even parity -> dest 3
        step(1'b1, 2'd0, 4'b0000, 4'b0010);
        settle();
        chk("bb_in_ready", 64'(in_ready), 64'h1);
        step(1'b0, 2'd0, 4'b0000, 4'b0000);
        settle();
        chk("bb_out_valid", 64'(out_valid), 64'h8);
        chk("bb_out_data", 64'(out_data), 64'h1100_0000);
        chk("bb_route_dest", 64'(route_dest), 64'h3);

        // Request while blocked is not latched
        step(1'b1, 2'd1, 4'b0111, 4'b0000);
        settle();
        chk("blk_in_ready", 64'(in_ready), 64'h0);
        step(1'b0, 2'd1, 4'b0111, 4'b0000);
        settle();
        chk("blk_out_valid", 64'(out_valid), 64'h8);
        chk("blk_route_dest", 64'(route_dest), 64'h3);

        // Asynchronous reset while an entry is held
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_out_data", 64'(out_data), 64'h0);
        chk("arst_route_dest", 64'(route_dest), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        step(1'b0, 2'd0, 4'b0000, 4'b1111);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("post_rst_quiet", 64'(out_valid), 64'h0);
        end

        // Mixed traffic checked by the model each cycle
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
            in_data = $urandom;
        end
        step(1'b0, 2'd0, 4'b0000, 4'b1111);
        step(1'b0, 2'd0, 4'b0000, 4'b0000);
        settle();
        chk("mix_idle", 64'(out_valid), 64'h0);

`ifdef ROUTER_STATS_EN
        // Saturation: a continuous stream of drains to channel 0
        for (int i = 0; i < 302; i++) step(1'b1, 2'd0, 4'b0001, 4'b0001);
        step(1'b0, 2'd0, 4'b0001, 4'b0001);
        step(1'b0, 2'd0, 4'b0001, 4'b0000);
        settle();
        chk("sat_cnt0", 64'(cnt_flat[7:0]), 64'd255);
        // Clear coincident with a drain wins
        step(1'b1, 2'd0, 4'b0001, 4'b0001);
        step(1'b1, 2'd0, 4'b0001, 4'b0001);
        cnt_clr = 1'b1;
        step(1'b0, 2'd0, 4'b0001, 4'b0000);
        cnt_clr = 1'b0;
        settle();
        chk("clr_cnt0", 64'(cnt_flat[7:0]), 64'd0);
        step(1'b0, 2'd0, 4'b0001, 4'b0001);
        step(1'b0, 2'd0, 4'b0001, 4'b0000);
        settle();
        chk("after_clr_cnt0", 64'(cnt_flat[7:0]), 64'd1);
`endif

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
